// File: rtl/assert_report_arbiter.sv
// Serialises failure pulses from bound assertion checkers onto one valid/ready report channel.
// The arbiter is round-robin, with a post-reset quiet window and saturating total/drop counters.
module assert_report_arbiter #(
  parameter int unsigned NUM_CHK   = 4,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned QUIET_CYC = 8,
  localparam int unsigned IdW      = (NUM_CHK > 1) ? $clog2(NUM_CHK) : 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clr,
  input  logic [NUM_CHK-1:0] chk_en,
  input  logic [NUM_CHK-1:0] chk_fail,
  output logic               rpt_valid,
  input  logic               rpt_ready,
  output logic [IdW-1:0]     rpt_id,
  output logic [CNT_W-1:0]   total_cnt,
  output logic [CNT_W-1:0]   drop_cnt,
  output logic               quiet
);

  localparam int unsigned QW    = (QUIET_CYC > 1) ? $clog2(QUIET_CYC) : 1;
  localparam int unsigned PopW  = $clog2(NUM_CHK + 1);
  localparam int unsigned SumW  = CNT_W + PopW;
  localparam int unsigned CandW = IdW + 1;
  localparam logic [QW-1:0] QuietLast = QW'((QUIET_CYC > 0) ? QUIET_CYC - 1 : 0);

  typedef enum logic [1:0] {StQuiet, StIdle, StReport} state_e;

  localparam state_e ResetState = (QUIET_CYC == 0) ? StIdle : StQuiet;

  state_e             state_q, state_d;
  logic [QW-1:0]      qcnt_q, qcnt_d;
  logic [NUM_CHK-1:0] pending_q, pending_d;
  logic [IdW-1:0]     rr_q, rr_d;
  logic               valid_q, valid_d;
  logic [IdW-1:0]     id_q, id_d;
  logic [CNT_W-1:0]   total_q, total_d;
  logic [CNT_W-1:0]   drop_q, drop_d;

  logic [NUM_CHK-1:0] eff;
  logic [NUM_CHK-1:0] hs_mask;
  logic               hs;
  logic               sel_found;
  logic [IdW-1:0]     sel_id;
  logic [CandW-1:0]   cand;

  function automatic logic [PopW-1:0] popcount(input logic [NUM_CHK-1:0] v);
    logic [PopW-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_CHK; i++) begin
      n = n + PopW'(v[i]);
    end
    return n;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [PopW-1:0]  b);
    logic [SumW-1:0] s;
    s = SumW'(a) + SumW'(b);
    if (s > SumW'({CNT_W{1'b1}})) begin
      return '1;
    end
    return s[CNT_W-1:0];
  endfunction

  assign quiet = (state_q == StQuiet);
  assign eff   = chk_fail & chk_en & {NUM_CHK{~quiet}};
  assign hs    = (state_q == StReport) && rpt_ready;

  always_comb begin
    hs_mask = '0;
    if (hs) begin
      hs_mask[id_q] = 1'b1;
    end
  end

  // Search starts at the round-robin pointer and wraps; pointer and offset are both < NUM_CHK.
  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    cand      = '0;
    for (int off = 0; off < NUM_CHK; off++) begin
      cand = {1'b0, rr_q} + CandW'(off);
      if (cand >= CandW'(NUM_CHK)) begin
        cand = cand - CandW'(NUM_CHK);
      end
      if (!sel_found && pending_q[cand[IdW-1:0]]) begin
        sel_found = 1'b1;
        sel_id    = cand[IdW-1:0];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    qcnt_d    = qcnt_q;
    pending_d = pending_q;
    rr_d      = rr_q;
    valid_d   = valid_q;
    id_d      = id_q;
    total_d   = total_q;
    drop_d    = drop_q;

    if (clr) begin
      pending_d = '0;
      total_d   = '0;
      drop_d    = '0;
      rr_d      = '0;
      valid_d   = 1'b0;
      if (state_q != StQuiet) begin
        state_d = StIdle;
      end
    end else begin
      // A new fail on the checker being acknowledged re-arms it and is not a drop.
      pending_d = (pending_q & ~hs_mask) | eff;
      total_d   = sat_add(total_q, popcount(eff));
      drop_d    = sat_add(drop_q, popcount(eff & pending_q & ~hs_mask));
      unique case (state_q)
        StIdle: begin
          if (sel_found) begin
            valid_d = 1'b1;
            id_d    = sel_id;
            state_d = StReport;
          end
        end
        StReport: begin
          if (rpt_ready) begin
            valid_d = 1'b0;
            state_d = StIdle;
            rr_d    = (id_q == IdW'(NUM_CHK - 1)) ? '0 : id_q + IdW'(1);
          end
        end
        default: ;
      endcase
    end

    // The quiet window keeps running through a soft clear.
    if (state_q == StQuiet) begin
      qcnt_d = qcnt_q + QW'(1);
      if (qcnt_q == QuietLast) begin
        state_d = StIdle;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ResetState;
      qcnt_q    <= '0;
      pending_q <= '0;
      rr_q      <= '0;
      valid_q   <= 1'b0;
      id_q      <= '0;
      total_q   <= '0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      qcnt_q    <= qcnt_d;
      pending_q <= pending_d;
      rr_q      <= rr_d;
      valid_q   <= valid_d;
      id_q      <= id_d;
      total_q   <= total_d;
      drop_q    <= drop_d;
    end
  end

  assign rpt_valid = valid_q;
  assign rpt_id    = id_q;
  assign total_cnt = total_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_assert_report_arbiter.sv
// Bench for assert_report_arbiter: directed vector table, hand-written corner sequences and
// randomized traffic checked against a cycle-level behavioural model.
module tb_assert_report_arbiter;

  localparam int unsigned NumChk   = 4;
  localparam int unsigned CntW     = 4;
  localparam int unsigned QuietCyc = 8;
  localparam int          CntMax   = 15;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            clr;
  logic [3:0]      chk_en;
  logic [3:0]      chk_fail;
  logic            rpt_valid;
  logic            rpt_ready;
  logic [1:0]      rpt_id;
  logic [CntW-1:0] total_cnt;
  logic [CntW-1:0] drop_cnt;
  logic            quiet;

  assert_report_arbiter #(
    .NUM_CHK  (NumChk),
    .CNT_W    (CntW),
    .QUIET_CYC(QuietCyc)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr      (clr),
    .chk_en   (chk_en),
    .chk_fail (chk_fail),
    .rpt_valid(rpt_valid),
    .rpt_ready(rpt_ready),
    .rpt_id   (rpt_id),
    .total_cnt(total_cnt),
    .drop_cnt (drop_cnt),
    .quiet    (quiet)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: pending set, a single report slot, integer counters clipped at CntMax.
  bit m_pend[NumChk];
  bit m_valid;
  int m_id, m_rr, m_total, m_drop, m_quiet_left;

  function automatic void model_reset();
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_valid      = 1'b0;
    m_id         = 0;
    m_rr         = 0;
    m_total      = 0;
    m_drop       = 0;
    m_quiet_left = QuietCyc;
  endfunction

  function automatic void model_step();
    bit qn, hs;
    bit old[NumChk];
    bit e[NumChk];
    int n_eff, n_drop, c;
    if (!reset_n) begin
      model_reset();
      return;
    end
    qn = (m_quiet_left > 0);
    if (clr) begin
      foreach (m_pend[i]) m_pend[i] = 1'b0;
      m_total = 0;
      m_drop  = 0;
      m_rr    = 0;
      m_valid = 1'b0;
    end else begin
      hs     = m_valid && rpt_ready;
      old    = m_pend;
      n_eff  = 0;
      n_drop = 0;
      for (int i = 0; i < NumChk; i++) begin
        e[i] = chk_fail[i] && chk_en[i] && !qn;
        if (e[i]) begin
          n_eff++;
          if (old[i] && !(hs && m_id == i)) n_drop++;
        end
      end
      if (hs) begin
        m_pend[m_id] = 1'b0;
        m_rr         = (m_id + 1) % NumChk;
        m_valid      = 1'b0;
      end else if (!m_valid && !qn) begin
        for (int k = 0; k < NumChk; k++) begin
          c = (m_rr + k) % NumChk;
          if (old[c]) begin
            m_valid = 1'b1;
            m_id    = c;
            break;
          end
        end
      end
      for (int i = 0; i < NumChk; i++) if (e[i]) m_pend[i] = 1'b1;
      m_total = (m_total + n_eff > CntMax) ? CntMax : m_total + n_eff;
      m_drop  = (m_drop + n_drop > CntMax) ? CntMax : m_drop + n_drop;
    end
    if (m_quiet_left > 0) m_quiet_left--;
  endfunction

  task automatic compare_model();
    check("model.rpt_valid", int'(rpt_valid), int'(m_valid));
    check("model.quiet", int'(quiet), int'(m_quiet_left > 0));
    check("model.total_cnt", int'(total_cnt), m_total);
    check("model.drop_cnt", int'(drop_cnt), m_drop);
    if (m_valid) check("model.rpt_id", int'(rpt_id), m_id);
  endtask

  // One clock: model advances on the edge, outputs are sampled 1 ns later.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_model();
  endtask

  typedef struct {
    bit         clr;
    logic [3:0] fail;
    bit         ready;
    bit         ev;
    int         eid;
    int         et;
    int         ed;
    bit         eq;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(bit c, logic [3:0] f, bit r, bit ev, int eid, int et, int ed,
                              bit eq);
    vec_t v;
    v.clr = c; v.fail = f; v.ready = r; v.ev = ev; v.eid = eid; v.et = et; v.ed = ed; v.eq = eq;
    vecs.push_back(v);
  endfunction

  bit seen0, seen2;

  initial begin
    reset_n   = 1'b0;
    clr       = 1'b0;
    chk_en    = 4'hF;
    chk_fail  = 4'h0;
    rpt_ready = 1'b0;
    model_reset();

    // Each row is one cycle after reset release; expectations are the outputs after its edge.
    // Quiet window: fail in cycle 3 ignored, fail in cycle 9 reported from cycle 11.
    add(0, 4'h0, 0, 0, 0, 0, 0, 1);
    add(0, 4'h0, 0, 0, 0, 0, 0, 1);
    add(0, 4'h1, 0, 0, 0, 0, 0, 1);
    for (int i = 4; i <= 7; i++) add(0, 4'h0, 0, 0, 0, 0, 0, 1);
    add(0, 4'h0, 0, 0, 0, 0, 0, 0);
    add(0, 4'h1, 0, 0, 0, 1, 0, 0);
    add(0, 4'h0, 0, 1, 0, 1, 0, 0);
    add(0, 4'h0, 1, 0, 0, 1, 0, 0);
    add(0, 4'h0, 1, 0, 0, 1, 0, 0);
    // Round-robin: all four fail together, ids 0..3 every other cycle.
    add(1, 4'h0, 1, 0, 0, 0, 0, 0);
    add(0, 4'hF, 1, 0, 0, 4, 0, 0);
    for (int i = 0; i < 4; i++) begin
      add(0, 4'h0, 1, 1, i, 4, 0, 0);
      add(0, 4'h0, 1, 0, 0, 4, 0, 0);
    end
    add(0, 4'h0, 1, 0, 0, 4, 0, 0);
    // Backpressure: three fails on checker 2 give one report and two drops.
    add(0, 4'h4, 0, 0, 0, 5, 0, 0);
    add(0, 4'h0, 0, 1, 2, 5, 0, 0);
    add(0, 4'h4, 0, 1, 2, 6, 1, 0);
    add(0, 4'h0, 0, 1, 2, 6, 1, 0);
    add(0, 4'h4, 0, 1, 2, 7, 2, 0);
    add(0, 4'h0, 1, 0, 0, 7, 2, 0);
    add(0, 4'h0, 1, 0, 0, 7, 2, 0);
    add(0, 4'h0, 1, 0, 0, 7, 2, 0);
    // Set wins over the handshake clear of the same checker.
    add(0, 4'h2, 0, 0, 0, 8, 2, 0);
    add(0, 4'h0, 0, 1, 1, 8, 2, 0);
    add(0, 4'h2, 1, 0, 0, 9, 2, 0);
    add(0, 4'h0, 1, 1, 1, 9, 2, 0);
    add(0, 4'h0, 1, 0, 0, 9, 2, 0);
    add(0, 4'h0, 1, 0, 0, 9, 2, 0);

    repeat (3) cycle();
    check("reset.rpt_valid", int'(rpt_valid), 0);
    check("reset.rpt_id", int'(rpt_id), 0);
    check("reset.total_cnt", int'(total_cnt), 0);
    check("reset.drop_cnt", int'(drop_cnt), 0);
    check("reset.quiet", int'(quiet), 1);
    reset_n = 1'b1;

    for (int n = 0; n < vecs.size(); n++) begin
      clr       = vecs[n].clr;
      chk_fail  = vecs[n].fail;
      rpt_ready = vecs[n].ready;
      cycle();
      check($sformatf("vec[%0d].rpt_valid", n), int'(rpt_valid), int'(vecs[n].ev));
      check($sformatf("vec[%0d].total_cnt", n), int'(total_cnt), vecs[n].et);
      check($sformatf("vec[%0d].drop_cnt", n), int'(drop_cnt), vecs[n].ed);
      check($sformatf("vec[%0d].quiet", n), int'(quiet), int'(vecs[n].eq));
      if (vecs[n].ev) check($sformatf("vec[%0d].rpt_id", n), int'(rpt_id), vecs[n].eid);
    end

    // Enable mask and saturation: 20 cycles of all-fail with only checkers 0 and 2 enabled.
    clr      = 1'b1;
    chk_fail = 4'h0;
    cycle();
    check("sat.clr_total", int'(total_cnt), 0);
    clr       = 1'b0;
    chk_en    = 4'b0101;
    chk_fail  = 4'hF;
    rpt_ready = 1'b1;
    seen0     = 1'b0;
    seen2     = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (rpt_valid) begin
        check("sat.masked_id", int'(rpt_id == 2'd1 || rpt_id == 2'd3), 0);
        if (rpt_id == 2'd0) seen0 = 1'b1;
        if (rpt_id == 2'd2) seen2 = 1'b1;
      end
    end
    check("sat.total_cnt", int'(total_cnt), 15);
    check("sat.drop_cnt", int'(drop_cnt), 15);
    check("sat.seen_id0", int'(seen0), 1);
    check("sat.seen_id2", int'(seen2), 1);
    chk_fail = 4'h0;
    repeat (6) cycle();

    // Reset while a report is outstanding.
    chk_en    = 4'hF;
    rpt_ready = 1'b0;
    chk_fail  = 4'h1;
    cycle();
    chk_fail = 4'h0;
    cycle();
    cycle();
    check("rst_mid.pre_valid", int'(rpt_valid), 1);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check("rst_mid.rpt_valid", int'(rpt_valid), 0);
    check("rst_mid.total_cnt", int'(total_cnt), 0);
    check("rst_mid.drop_cnt", int'(drop_cnt), 0);
    check("rst_mid.quiet", int'(quiet), 1);
    cycle();
    cycle();
    reset_n = 1'b1;
    for (int i = 1; i <= int'(QuietCyc); i++) begin
      cycle();
      check("rst_mid.quiet_window", int'(quiet), int'(i < int'(QuietCyc)));
    end

    // Randomized traffic, including soft clears and occasional resets.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        reset_n = 1'b0;
        model_reset();
      end else begin
        reset_n = 1'b1;
      end
      if ($urandom_range(0, 19) == 0) chk_en = 4'($urandom);
      chk_fail  = 4'($urandom) & 4'($urandom);
      rpt_ready = ($urandom_range(0, 2) != 0);
      clr       = ($urandom_range(0, 29) == 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/assert_report_arbiter.md
# assert_report_arbiter

Collects failure pulses from up to NUM_CHK bound assertion checkers (one per bound instance of an assertion module) and serialises them onto a single valid/ready report channel toward the testbench log/scoreboard. It sits beside the interface that the checkers monitor. It suppresses reports during a programmable quiet window after reset release, which mirrors the checkers' disable-iff behaviour. It also keeps total and dropped failure counts.

## Interface
Parameters:
- NUM_CHK, 4: number of checker fail inputs (1..32).
- CNT_W, 16: width of the failure counters (saturating).
- QUIET_CYC, 8: cycles after reset deassertion during which fail inputs are ignored (0 = no quiet window).

Ports:
- clk, in, 1: single clock; all logic on posedge.
- reset_n, in, 1: one clock; reset is asynchronous and active-low.
- clr, in, 1: synchronous soft clear of pending bits, counters and round-robin pointer; does not restart the quiet window.
- chk_en, in, NUM_CHK: per-checker enable mask; fails from disabled checkers are ignored entirely.
- chk_fail, in, NUM_CHK: one-cycle (or level) failure indication per checker, sampled each posedge.
- rpt_valid, out, 1: report available.
- rpt_ready, in, 1: consumer accepts report.
- rpt_id, out, $clog2(NUM_CHK) (min 1): index of the failing checker being reported.
- total_cnt, out, CNT_W: accepted failures (saturates at all-ones).
- drop_cnt, out, CNT_W: failures lost because that checker was already pending (saturates).
- quiet, out, 1: high while the quiet window is active.

## Operation
- Reset values: rpt_valid=0, rpt_id=0, total_cnt=0, drop_cnt=0, pending=0, rr pointer=0, quiet=1 (quiet=0 if QUIET_CYC=0), FSM=QUIET (IDLE if QUIET_CYC=0).
- Effective fail: eff[i] = chk_fail[i] & chk_en[i] & ~quiet.
- Each eff[i] sets pending[i] and increments total_cnt by 1.
- If pending[i] was already set and is not being cleared this cycle, drop_cnt also increments. Multiple simultaneous fails add their popcount to each counter, saturating.
- FSM states:
  - QUIET: count QUIET_CYC cycles, then go to IDLE.
  - IDLE: if any pending, select the lowest index at or above rr pointer (wrapping). Load rpt_id, set rpt_valid, go to REPORT.
  - REPORT: hold rpt_valid and rpt_id stable until rpt_ready.
    - On handshake: clear pending[rpt_id], set rr = rpt_id+1 (mod NUM_CHK), drop rpt_valid, return to IDLE.
- A fail on checker rpt_id in the handshake cycle re-sets its pending bit. Set wins over clear. It is not counted as dropped.
- Pending bits stay set even after chk_en is deasserted; they are still reported.
- clr: pending=0, counters=0, rr=0, rpt_valid=0, FSM to IDLE (or stays QUIET if active). Fails in the clr cycle are discarded.
- reset_n low at any point: immediate asynchronous return to reset values. An in-flight report is abandoned.

## Timing
- Fail high in cycle k sets pending at edge end-of-k. Selection happens in cycle k+1. rpt_valid is high from cycle k+2 (latency 2).
- After a handshake in cycle m, the earliest next rpt_valid is cycle m+2. Throughput is one report per 2 cycles while rpt_ready is held high.
- Quiet window: rising edge of reset_n, then QUIET_CYC full clock cycles with quiet=1. Fails are accepted from the next cycle.
- rpt_valid never drops without a handshake, except on clr or reset. rpt_id never changes while rpt_valid=1.
- Fairness: a continuously failing checker cannot starve the others. Every pending checker is reported within NUM_CHK grants.

## Test plan
- Quiet window: QUIET_CYC=8, pulse chk_fail[0] in cycles 3 and 9 after reset release. Required: only the cycle-9 fail is reported; total_cnt=1; rpt_valid rises at cycle 11.
- Round-robin: all 4 fails pulse simultaneously, rpt_ready=1. Required: rpt_id sequence 0,1,2,3 on cycles k+2,k+4,k+6,k+8; total_cnt=4; drop_cnt=0.
- Backpressure/drop: rpt_ready=0, pulse chk_fail[2] three times. Required: rpt_valid held with rpt_id=2 stable; total_cnt=3; drop_cnt=2; release ready gives exactly one report.
- Set-wins: chk_fail[1] pulses in the handshake cycle of id 1. Required: id 1 is reported again; drop_cnt unchanged.
- Enable mask/saturation: chk_en=4'b0101, CNT_W=4, 20 fails on all inputs. Required: only ids 0 and 2 are reported; total_cnt stays at 15.
- Reset mid-report: assert reset_n low while rpt_valid=1. Required: rpt_valid=0 and counters=0 immediately; quiet=1 after release.
